recip_nr_seq: RTL



---
 rtl/recip_nr_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/recip_nr_seq.sv
// recip_nr_seq: sequential UQ8.8 reciprocal built from a linear seed and
// ITERS Newton-Raphson refinements on a single shared 16x16 multiplier.
// The operand is normalised to [0.5,1) with the upstream leading-zero count.
// The result is then denormalised back to UQ8.8.
// Build option: define RECIP_ROUND_EN to round half-up in the final shift.
// The default build truncates.
module recip_nr_seq #(
  parameter int          ITERS  = 3,
  parameter logic [15:0] SEED_A = 16'hB4B5,
  parameter logic [15:0] SEED_B = 16'h7878
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [3:0]  in_lzc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        out_sat,
  output logic        out_dbz
);

  typedef enum logic [2:0] {
    IDLE, SEED, MUL_T, MUL_Y, DENORM, DONE
  } state_t;

  state_t      state_q;
  logic [15:0] x_q, m_q, y_q, e_q, r_q;
  logic [3:0]  lzc_q;
  logic [2:0]  iter_q;
  logic        seedPh_q;
  logic        inReady_q, outValid_q, sat_q, dbz_q;

  logic [15:0] mulA, mulB;
  logic [31:0] prod;
  logic [15:0] seedY, tVal, eVal, yNew;
  logic [17:0] yRaw;
  logic [30:0] wVal, wRnd;
  logic [16:0] rVal;
  logic [2:0]  iterNext;

  // Shared multiplier: operand selection depends on which step is running,
  // and every step's result is derived from the same 32-bit product.
  always_comb begin
    mulA = 16'd0;
    mulB = 16'd0;
    case (state_q)
      SEED:    begin mulA = SEED_B; mulB = m_q; end
      MUL_T:   begin mulA = m_q;    mulB = y_q; end
      MUL_Y:   begin mulA = y_q;    mulB = e_q; end
      default: begin mulA = 16'd0;  mulB = 16'd0; end
    endcase
    prod  = {16'd0, mulA} * {16'd0, mulB};
    seedY = SEED_A - prod[31:16];
    tVal  = prod[31:16];
    eVal  = (tVal >= 16'h8000) ? 16'h0000 : (16'h8000 - tVal);
    yRaw  = prod[31:14];
    if (yRaw < 18'h04000)
      yNew = 16'h4000;
    else if (yRaw > 18'h08000)
      yNew = 16'h8000;
    else
      yNew = yRaw[15:0];
    iterNext = iter_q + 3'd1;
  end

  // Denormalisation: shift the UQ2.14 estimate back by the leading-zero
  // count. Bit 16 of the shifted result marks an out-of-range reciprocal.
  always_comb begin
    wVal = {15'd0, y_q} << lzc_q;
`ifdef RECIP_ROUND_EN
    wRnd = wVal + 31'd8192;
`else
    wRnd = wVal;
`endif
    rVal = wRnd[30:14];
  end

  // Control FSM with all datapath and handshake registers.
  // The first SEED cycle normalises the operand and the second forms the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= 16'd0;
      m_q        <= 16'd0;
      y_q        <= 16'd0;
      e_q        <= 16'd0;
      r_q        <= 16'd0;
      lzc_q      <= 4'd0;
      iter_q     <= 3'd0;
      seedPh_q   <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      sat_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            x_q       <= in_x;
            lzc_q     <= in_lzc;
            seedPh_q  <= 1'b0;
            inReady_q <= 1'b0;
            state_q   <= SEED;
          end
        end
        SEED: begin
          if (!seedPh_q) begin
            m_q      <= x_q << lzc_q;
            seedPh_q <= 1'b1;
          end else if (x_q == 16'd0) begin
            r_q        <= 16'hFFFF;
            sat_q      <= 1'b1;
            dbz_q      <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            y_q     <= seedY;
            iter_q  <= 3'd0;
            state_q <= MUL_T;
          end
        end
        MUL_T: begin
          e_q     <= eVal;
          state_q <= MUL_Y;
        end
        MUL_Y: begin
          y_q    <= yNew;
          iter_q <= iterNext;
          if (iterNext < 3'(ITERS))
            state_q <= MUL_T;
          else
            state_q <= DENORM;
        end
        DENORM: begin
          r_q        <= rVal[16] ? 16'hFFFF : rVal[15:0];
          sat_q      <= rVal[16];
          dbz_q      <= 1'b0;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_r     = r_q;
  assign out_sat   = sat_q;
  assign out_dbz   = dbz_q;

endmodule
